// File: rtl/test_sum.sv
// Full-adder sum/carry with registered outputs, plus a running parity and a
// saturating ones-count of the combinational sum bit f.
module test_sum #(
  parameter int unsigned CNT_W = 8
) (
  output logic             f,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic             s_q,
  output logic             co_q,
  output logic             par_q,
  output logic [CNT_W-1:0] ones_q
);

  logic             w_sum;
  logic             w_maj;
  logic             w_ones_sat;
  logic             w_par_nxt;
  logic [CNT_W-1:0] w_ones_nxt;

  logic             r_s;
  logic             r_co;
  logic             r_par;
  logic [CNT_W-1:0] r_ones;

  always_comb begin
    w_sum = a ^ b ^ c;
    w_maj = (a & b) | (a & c) | (b & c);
  end

  // clr wins over counting; the current f is dropped on a clearing edge
  always_comb begin
    w_ones_sat = (r_ones == {CNT_W{1'b1}});
    w_par_nxt  = r_par;
    w_ones_nxt = r_ones;
    if (clr) begin
      w_par_nxt  = 1'b0;
      w_ones_nxt = '0;
    end else begin
      w_par_nxt = r_par ^ w_sum;
      if (w_sum && !w_ones_sat) begin
        w_ones_nxt = r_ones + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s    <= 1'b0;
      r_co   <= 1'b0;
      r_par  <= 1'b0;
      r_ones <= '0;
    end else begin
      r_s    <= w_sum;
      r_co   <= w_maj;
      r_par  <= w_par_nxt;
      r_ones <= w_ones_nxt;
    end
  end

  always_comb begin
    f      = w_sum;
    s_q    = r_s;
    co_q   = r_co;
    par_q  = r_par;
    ones_q = r_ones;
  end

endmodule

// File: tb/tb_test_sum.sv
// Bench for test_sum: one default-width and one 2-bit-counter instance driven
// in lockstep, compared against an arithmetic reference model.
module tb_test_sum;

  logic       a, b, c, clk, rst_n, clr;
  logic       f8, s8, co8, par8;
  logic [7:0] ones8;
  logic       f2, s2, co2, par2;
  logic [1:0] ones2;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit          m_s, m_co, m_par;
  int unsigned m_ones8, m_ones2;

  test_sum #(.CNT_W(8)) u_dut8 (
    .f(f8), .a(a), .b(b), .c(c), .clk(clk), .rst_n(rst_n), .clr(clr),
    .s_q(s8), .co_q(co8), .par_q(par8), .ones_q(ones8)
  );

  test_sum #(.CNT_W(2)) u_dut2 (
    .f(f2), .a(a), .b(b), .c(c), .clk(clk), .rst_n(rst_n), .clr(clr),
    .s_q(s2), .co_q(co2), .par_q(par2), .ones_q(ones2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s = 0; m_co = 0; m_par = 0; m_ones8 = 0; m_ones2 = 0;
  endtask

  function automatic int unsigned sum3();
    return int'(a) + int'(b) + int'(c);
  endfunction

  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  // apply inputs, advance the model by one edge, clock the DUTs
  task automatic step(input bit ia, input bit ib, input bit ic, input bit iclr);
    int unsigned s;
    a = ia; b = ib; c = ic; clr = iclr;
    #1;
    s    = sum3();
    m_s  = s[0];
    m_co = s[1];
    if (iclr) begin
      m_par = 0; m_ones8 = 0; m_ones2 = 0;
    end else begin
      m_par = m_par ^ s[0];
      if (s[0]) begin
        if (m_ones8 < 255) m_ones8++;
        if (m_ones2 < 3)   m_ones2++;
      end
    end
    tick();
  endtask

  task automatic check_all(input string tag);
    int unsigned s;
    s = sum3();
    chk({tag, ".f8"},    32'(f8),    32'(s[0]));
    chk({tag, ".f2"},    32'(f2),    32'(s[0]));
    chk({tag, ".s8"},    32'(s8),    32'(m_s));
    chk({tag, ".co8"},   32'(co8),   32'(m_co));
    chk({tag, ".par8"},  32'(par8),  32'(m_par));
    chk({tag, ".ones8"}, 32'(ones8), m_ones8);
    chk({tag, ".s2"},    32'(s2),    32'(m_s));
    chk({tag, ".co2"},   32'(co2),   32'(m_co));
    chk({tag, ".par2"},  32'(par2),  32'(m_par));
    chk({tag, ".ones2"}, 32'(ones2), m_ones2);
  endtask

  initial begin
    logic [7:0] f_tab;
    clk = 0; rst_n = 0; clr = 0; a = 0; b = 0; c = 0;
    model_reset();
    #3;
    check_all("reset");

    // combinational sweep, no clock
    f_tab = 8'b1001_0110;
    for (int i = 0; i < 8; i++) begin
      {a, b, c} = 3'(i);
      #1;
      chk($sformatf("sweep%0d.f8", i), 32'(f8), 32'(f_tab[i]));
      chk($sformatf("sweep%0d.f2", i), 32'(f2), 32'(f_tab[i]));
    end

    // clock edges while held in reset must not load anything
    a = 1; b = 1; c = 1;
    tick(); tick();
    check_all("reset_prio");

    #2 rst_n = 1;
    #2;
    step(1, 1, 1, 0);
    chk("add111.s", 32'(s8), 32'd1);
    chk("add111.co", 32'(co8), 32'd1);
    step(1, 1, 0, 0);
    chk("add110.s", 32'(s8), 32'd0);
    chk("add110.co", 32'(co8), 32'd1);
    check_all("add");

    // fresh reset, then f=1 for 5 edges
    rst_n = 0; #2; model_reset(); rst_n = 1; #2;
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    chk("ones5", 32'(ones8), 32'd5);
    chk("par5", 32'(par8), 32'd1);
    step(0, 1, 0, 0);
    chk("sat2", 32'(ones2), 32'd3);
    check_all("count6");

    // clear with f=1
    step(1, 0, 0, 1);
    chk("clr.par", 32'(par8), 32'd0);
    chk("clr.ones", 32'(ones8), 32'd0);
    chk("clr.s", 32'(s8), 32'd1);
    check_all("clr");

    // saturate the 8-bit counter
    for (int i = 0; i < 300; i++) step(1, 1, 1, 0);
    chk("sat8", 32'(ones8), 32'd255);
    check_all("sat");

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
      check_all($sformatf("rnd%0d", i));
    end

    // mid-operation async reset between edges
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all("async_rst");
    a = 0; b = 1; c = 1;
    #1;
    chk("async_rst.f_track", 32'(f8), 32'd0);
    a = 1;
    #1;
    chk("async_rst.f_track2", 32'(f8), 32'd1);
    check_all("async_rst2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
